// File: rtl/bp_bht_btb_pkg.sv
// Shared encodings for the branch predictor: E-stage jump codes and 2-bit counter states.
// Ports: none (package only).
// The jump-code values match the E-stage encoding bit for bit, so no translation is needed.
package bp_pkg;

  typedef logic [1:0] jc_t;
  typedef logic [1:0] ctr_t;

  localparam jc_t JC_NONE = 2'b00;
  localparam jc_t JC_BR   = 2'b01;
  localparam jc_t JC_JAL  = 2'b10;
  localparam jc_t JC_JALR = 2'b11;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

endpackage

// File: rtl/bp_bht_btb_if.sv
// Fetch-lookup / E-stage-training / perf-counter bundle between the pipeline and the predictor.
// Ports: master = pipeline side (drives f_pc and e_*), slave = predictor side (drives predictions and perf counters).
// Lookup is zero-latency; training takes effect on the next clock edge.
interface bp_bht_btb_if
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  f_pc;
  logic             f_pred_taken;
  logic [XLEN-1:0]  f_pred_pc;
  logic             e_valid;
  logic [XLEN-1:0]  e_pc;
  jc_t              e_jump_code;
  logic             e_taken;
  logic [XLEN-1:0]  e_target;
  logic             e_fail_predict;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispredicts;

  modport master (
    output f_pc, e_valid, e_pc, e_jump_code, e_taken, e_target, e_fail_predict,
    input  f_pred_taken, f_pred_pc, perf_branches, perf_mispredicts
  );

  modport slave (
    input  f_pc, e_valid, e_pc, e_jump_code, e_taken, e_target, e_fail_predict,
    output f_pred_taken, f_pred_pc, perf_branches, perf_mispredicts
  );

endinterface

// File: rtl/bp_bht_btb_ctr2.sv
// 2-bit saturating counter next-state function (combinational).
// Ports: cur_i = current state, taken_i = resolved direction, next_o = next state.
// Counts up toward strongly-taken on taken, down toward strongly-not-taken otherwise.
module bp_ctr2
  import bp_pkg::*;
(
  input  ctr_t cur_i,
  input  logic taken_i,
  output ctr_t next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != CTR_ST) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != CTR_SNT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/bp_bht_btb.sv
// Combined BHT/BTB: direct-mapped, tagged, register-based table looked up combinationally by fetch.
// Ports: clk, rst (sync, active-high), bus (slave side: f_pc lookup, e_* training, perf counters).
// Trained from E-stage resolution one cycle later; same-cycle lookups see pre-update contents.
module bp_bht_btb
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6,
  parameter int TAG_W = 10,
  parameter int CNT_W = 32
)
(
  input  logic          clk,
  input  logic          rst,
  bp_bht_btb_if.slave   bus
);

  localparam int N = 1 << IDX_W;

  logic             valid_q [N];
  logic [TAG_W-1:0] tag_q   [N];
  jc_t              type_q  [N];
  ctr_t             ctr_q   [N];
  logic [XLEN-1:0]  tgt_q   [N];

  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = bus.f_pc[IDX_W+1:2];
  assign f_tag = bus.f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  // Unconditional jumps always predict taken once known; branches follow the counter MSB.
  assign bus.f_pred_taken = f_hit && ((type_q[f_idx] != JC_BR) || ctr_q[f_idx][1]);
  assign bus.f_pred_pc    = bus.f_pred_taken ? tgt_q[f_idx] : bus.f_pc + XLEN'(4);

  // ---------------- training ----------------
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit, upd_en;
  ctr_t             ctr_nxt;

  assign e_idx  = bus.e_pc[IDX_W+1:2];
  assign e_tag  = bus.e_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign e_hit  = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign upd_en = bus.e_valid && (bus.e_jump_code != JC_NONE);

  bp_ctr2 u_ctr2 (
    .cur_i   (ctr_q[e_idx]),
    .taken_i (bus.e_taken),
    .next_o  (ctr_nxt)
  );

  logic             we;
  logic [TAG_W-1:0] tag_d;
  jc_t              type_d;
  ctr_t             ctr_d;
  logic [XLEN-1:0]  tgt_d;

  always_comb begin
    we     = 1'b0;
    tag_d  = tag_q[e_idx];
    type_d = type_q[e_idx];
    ctr_d  = ctr_q[e_idx];
    tgt_d  = tgt_q[e_idx];
    if (upd_en) begin
      if (e_hit) begin
        we = 1'b1;
        if (bus.e_jump_code == JC_BR) begin
          ctr_d = ctr_nxt;
          if (bus.e_taken) tgt_d = bus.e_target;
        end else begin
          // jal/jalr: always refresh the target so jalr follows its most recent destination.
          type_d = bus.e_jump_code;
          tgt_d  = bus.e_target;
          ctr_d  = CTR_ST;
        end
      end else if (bus.e_taken) begin
        // Allocate, evicting whatever occupied this index. Not-taken misses leave the table alone.
        we     = 1'b1;
        tag_d  = e_tag;
        type_d = bus.e_jump_code;
        tgt_d  = bus.e_target;
        ctr_d  = (bus.e_jump_code == JC_BR) ? CTR_WT : CTR_ST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (we) begin
      valid_q[e_idx] <= 1'b1;
      tag_q[e_idx]   <= tag_d;
      type_q[e_idx]  <= type_d;
      ctr_q[e_idx]   <= ctr_d;
      tgt_q[e_idx]   <= tgt_d;
    end
  end

  // ---------------- perf counters (saturating) ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (upd_en && !(&br_cnt_q))                     br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (bus.e_valid && bus.e_fail_predict && !(&mis_cnt_q)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign bus.perf_branches    = br_cnt_q;
  assign bus.perf_mispredicts = mis_cnt_q;

  // Byte-offset bits and PC bits above the tag never select or qualify an entry.
  logic unused_e_pc_bits;
  if (IDX_W + TAG_W + 2 < XLEN) begin : g_hi_unused
    assign unused_e_pc_bits = ^{bus.e_pc[1:0], bus.e_pc[XLEN-1:IDX_W+TAG_W+2]};
  end else begin : g_no_hi
    assign unused_e_pc_bits = ^bus.e_pc[1:0];
  end

endmodule

// File: tb/tb_bp_bht_btb.sv
module tb_bp_bht_btb;
  import bp_pkg::*;

  localparam int XLEN  = 32;
  localparam int IDX_W = 6;
  localparam int TAG_W = 10;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_bht_btb_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  bp_bht_btb #(.XLEN(XLEN), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int passed = 0;

  task automatic idle_e();
    bus.e_valid        = 1'b0;
    bus.e_pc           = '0;
    bus.e_jump_code    = JC_NONE;
    bus.e_taken        = 1'b0;
    bus.e_target       = '0;
    bus.e_fail_predict = 1'b0;
  endtask

  task automatic do_reset();
    idle_e();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one training event for exactly one clock edge.
  task automatic upd(input logic [31:0] pc, input jc_t jc, input logic tk,
                     input logic [31:0] tgt, input logic fail);
    bus.e_valid        = 1'b1;
    bus.e_pc           = pc;
    bus.e_jump_code    = jc;
    bus.e_taken        = tk;
    bus.e_target       = tgt;
    bus.e_fail_predict = fail;
    @(posedge clk);
    #1 idle_e();
  endtask

  task automatic look(input logic [31:0] pc);
    bus.f_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    look(32'h100);
    total++; if (bus.f_pred_taken !== 1'b0) $display("FAIL reset_taken got=%0b want=0", bus.f_pred_taken); else passed++;
    total++; if (bus.f_pred_pc !== 32'h104) $display("FAIL reset_pc got=%h want=00000104", bus.f_pred_pc); else passed++;
    total++; if (bus.perf_branches !== 4'd0) $display("FAIL reset_br got=%0d want=0", bus.perf_branches); else passed++;
    total++; if (bus.perf_mispredicts !== 4'd0) $display("FAIL reset_mis got=%0d want=0", bus.perf_mispredicts); else passed++;
  endtask

  task automatic test_alloc();
    do_reset();
    upd(32'h100, JC_BR, 1'b1, 32'h80, 1'b1);
    look(32'h100);
    total++; if (bus.f_pred_taken !== 1'b1) $display("FAIL alloc_taken got=%0b want=1", bus.f_pred_taken); else passed++;
    total++; if (bus.f_pred_pc !== 32'h80) $display("FAIL alloc_pc got=%h want=00000080", bus.f_pred_pc); else passed++;
    total++; if (bus.perf_branches !== 4'd1) $display("FAIL alloc_br got=%0d want=1", bus.perf_branches); else passed++;
    total++; if (bus.perf_mispredicts !== 4'd1) $display("FAIL alloc_mis got=%0d want=1", bus.perf_mispredicts); else passed++;
    // Allocated at weakly-taken: a single not-taken flips the prediction.
    upd(32'h100, JC_BR, 1'b0, 32'h0, 1'b1);
    look(32'h100);
    total++; if (bus.f_pred_pc !== 32'h104) $display("FAIL alloc_ctr_wt got=%h want=00000104", bus.f_pred_pc); else passed++;
  endtask

  task automatic test_hysteresis();
    do_reset();
    upd(32'h100, JC_BR, 1'b1, 32'h80, 1'b0);      // ctr 10
    upd(32'h100, JC_BR, 1'b0, 32'h999, 1'b0);     // 01
    upd(32'h100, JC_BR, 1'b0, 32'h999, 1'b0);     // 00
    look(32'h100);
    total++; if (bus.f_pred_pc !== 32'h104) $display("FAIL hyst_00 got=%h want=00000104", bus.f_pred_pc); else passed++;
    upd(32'h100, JC_BR, 1'b0, 32'h999, 1'b0);     // stays 00
    upd(32'h100, JC_BR, 1'b1, 32'hC0, 1'b0);      // 01
    look(32'h100);
    total++; if (bus.f_pred_taken !== 1'b0) $display("FAIL hyst_sat_lo got=%0b want=0", bus.f_pred_taken); else passed++;
    upd(32'h100, JC_BR, 1'b1, 32'hC0, 1'b0);      // 10
    look(32'h100);
    total++; if (bus.f_pred_pc !== 32'hC0) $display("FAIL hyst_10 got=%h want=000000c0", bus.f_pred_pc); else passed++;
    upd(32'h100, JC_BR, 1'b1, 32'hC0, 1'b0);      // 11
    upd(32'h100, JC_BR, 1'b1, 32'hC0, 1'b0);      // stays 11
    upd(32'h100, JC_BR, 1'b0, 32'h999, 1'b0);     // 10, still taken, target kept
    look(32'h100);
    total++; if (bus.f_pred_pc !== 32'hC0) $display("FAIL hyst_sat_hi got=%h want=000000c0", bus.f_pred_pc); else passed++;
    upd(32'h100, JC_BR, 1'b0, 32'h999, 1'b0);     // 01
    look(32'h100);
    total++; if (bus.f_pred_pc !== 32'h104) $display("FAIL hyst_down got=%h want=00000104", bus.f_pred_pc); else passed++;
    total++; if (bus.perf_branches !== 4'd10) $display("FAIL hyst_br got=%0d want=10", bus.perf_branches); else passed++;
  endtask

  task automatic test_alias();
    do_reset();
    upd(32'h100, JC_BR, 1'b1, 32'h80, 1'b0);
    upd(32'h200, JC_JAL, 1'b1, 32'h300, 1'b0);
    look(32'h100);
    total++; if (bus.f_pred_pc !== 32'h104) $display("FAIL alias_evict got=%h want=00000104", bus.f_pred_pc); else passed++;
    look(32'h200);
    total++; if (bus.f_pred_taken !== 1'b1) $display("FAIL alias_jal_taken got=%0b want=1", bus.f_pred_taken); else passed++;
    total++; if (bus.f_pred_pc !== 32'h300) $display("FAIL alias_jal_pc got=%h want=00000300", bus.f_pred_pc); else passed++;
    upd(32'h200, JC_JALR, 1'b1, 32'h340, 1'b0);
    look(32'h200);
    total++; if (bus.f_pred_pc !== 32'h340) $display("FAIL jalr_track got=%h want=00000340", bus.f_pred_pc); else passed++;
    upd(32'h500, JC_BR, 1'b0, 32'h10, 1'b0);
    look(32'h500);
    total++; if (bus.f_pred_pc !== 32'h504) $display("FAIL miss_nt_noalloc got=%h want=00000504", bus.f_pred_pc); else passed++;
  endtask

  task automatic test_collision();
    do_reset();
    bus.f_pc           = 32'h40;
    bus.e_valid        = 1'b1;
    bus.e_pc           = 32'h40;
    bus.e_jump_code    = JC_BR;
    bus.e_taken        = 1'b1;
    bus.e_target       = 32'h1000;
    bus.e_fail_predict = 1'b1;
    #1;
    total++; if (bus.f_pred_pc !== 32'h44) $display("FAIL coll_same got=%h want=00000044", bus.f_pred_pc); else passed++;
    @(posedge clk);
    #1 idle_e();
    #1;
    total++; if (bus.f_pred_pc !== 32'h1000) $display("FAIL coll_next got=%h want=00001000", bus.f_pred_pc); else passed++;
  endtask

  task automatic test_sat_reset();
    do_reset();
    for (int i = 0; i < 20; i++)
      upd(32'h1000 + 32'(4 * i), JC_BR, 1'b1, 32'h2000, 1'b1);
    total++; if (bus.perf_mispredicts !== 4'd15) $display("FAIL sat_mis got=%0d want=15", bus.perf_mispredicts); else passed++;
    total++; if (bus.perf_branches !== 4'd15) $display("FAIL sat_br got=%0d want=15", bus.perf_branches); else passed++;
    look(32'h1000);
    total++; if (bus.f_pred_pc !== 32'h2000) $display("FAIL sat_pre_rst got=%h want=00002000", bus.f_pred_pc); else passed++;
    // Reset arrives together with a training event that must be dropped.
    rst = 1'b1;
    upd(32'h700, JC_BR, 1'b1, 32'h800, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    look(32'h700);
    total++; if (bus.f_pred_pc !== 32'h704) $display("FAIL rst_upd_drop got=%h want=00000704", bus.f_pred_pc); else passed++;
    look(32'h1000);
    total++; if (bus.f_pred_taken !== 1'b0) $display("FAIL rst_clear got=%0b want=0", bus.f_pred_taken); else passed++;
    total++; if (bus.perf_branches !== 4'd0) $display("FAIL rst_br got=%0d want=0", bus.perf_branches); else passed++;
    total++; if (bus.perf_mispredicts !== 4'd0) $display("FAIL rst_mis got=%0d want=0", bus.perf_mispredicts); else passed++;
  endtask

  initial begin
    bus.f_pc = 32'h0;
    idle_e();
    test_reset();
    test_alloc();
    test_hysteresis();
    test_alias();
    test_collision();
    test_sat_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bp_bht_btb.md
Name: bp_bht_btb

Overview:
- Parametrised branch predictor (combined BHT + BTB) for the RV32I pipeline.
- Looks up the fetch PC in the same cycle and supplies the predicted next PC to F.
- Trained by the E-stage resolution result: jump type, taken, target and mispredict flag.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- XLEN, 32, PC/target width.
- IDX_W, 6, log2 of table entries (64 entries); index = pc[IDX_W+1:2].
- TAG_W, 10, tag bits = pc[IDX_W+TAG_W+1:IDX_W+2]; IDX_W+TAG_W+2 <= XLEN.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- f_pc  in  XLEN  fetch PC to look up.
- f_pred_taken  out  1  prediction is taken.
- f_pred_pc  out  XLEN  predicted next PC.
- e_valid  in  1  E stage holds a valid, non-flushed instruction.
- e_pc  in  XLEN  PC of the E-stage instruction.
- e_jump_code  in  2  00 none, 01 conditional branch, 10 jal, 11 jalr.
- e_taken  in  1  resolved direction; jal and jalr are always 1.
- e_target  in  XLEN  resolved taken target.
- e_fail_predict  in  1  mispredict flag from the E stage.
- perf_branches  out  CNT_W  count of resolved control-transfer instructions.
- perf_mispredicts  out  CNT_W  count of mispredicts.

Behaviour:
- Each entry holds valid, tag[TAG_W], type[2], ctr[2] and target[XLEN].
- Storage is register-based so lookup is combinational. The only sequential state is the entries and the perf counters.
- Lookup:
  - hit = valid[idx] & tag[idx] == f_tag.
  - f_pred_taken = hit & (type != 01 | ctr[1]).
  - f_pred_pc = f_pred_taken ? target[idx] : f_pc + 4, with the add wrapping mod 2^XLEN.
- Update condition: write at the clk edge when e_valid & e_jump_code != 00 & !rst. The entry is the one selected by e_pc's index and tag.
- Update on a hit with a conditional branch:
  - ctr saturates: increments toward 11 if e_taken, decrements toward 00 otherwise.
  - target is written only if e_taken.
- Update on a miss with e_taken = 1 (allocate):
  - valid is set; tag and type are overwritten.
  - target = e_target.
  - ctr = 10 for a branch, 11 for jal/jalr.
  - Any previous occupant of the index is evicted.
- Update on a miss with e_taken = 0: no allocation and no state change.
- jal/jalr hit: type is set; target = e_target, so jalr tracks its last target; ctr = 11.
- Same cycle, same index for lookup and update: lookup returns pre-update contents. There is no write-through bypass.
- Perf counters:
  - perf_branches increments on e_valid & e_jump_code != 00.
  - perf_mispredicts increments on e_valid & e_fail_predict.
  - Both saturate at all-ones and never wrap.
- Reset:
  - All valid bits are 0, all ctr values 01, both perf counters 0.
  - tag, type and target are don't-care.
  - Result: f_pred_taken = 0 and f_pred_pc = f_pc + 4 in the cycle after reset.
- Update during reset: any update presented while rst is high is discarded, including one arriving mid-operation.
- Prediction outputs have zero latency. Update latency is 1 cycle: the next lookup sees the trained state.

Decomposition:
- Shared package bp_pkg holds:
  - jump-code constants JC_NONE = 00, JC_BR = 01, JC_JAL = 10, JC_JALR = 11, identical to the E-stage encoding;
  - counter constants CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11.
- One sub-module, bp_ctr2: a combinational 2-bit saturating next-state function with inputs cur and taken, output next. Instanced once in the update path.

Test Plan:
- Reset, then f_pc = 0x100 -> f_pred_taken = 0, f_pred_pc = 0x104; both perf counters 0.
- Taken-branch allocation: e_valid, e_pc = 0x100, jump_code 01, taken, target 0x80, fail_predict = 1.
  - Next cycle with f_pc = 0x100 -> taken, 0x80, ctr = 10.
  - perf_branches = 1, perf_mispredicts = 1.
- Counter hysteresis: two not-taken updates at 0x100 -> ctr goes 10 -> 01 -> 00, f_pred_pc = 0x104.
  - A further not-taken update stays at 00.
  - Three taken updates reach 11.
  - The fourth taken update stays at 11.
- Aliasing: allocate 0x100, then taken jal at 0x100 + 4 * 2^IDX_W (0x200 with defaults), target 0x300.
  - f_pc = 0x100 -> miss, 0x104.
  - f_pc = 0x200 -> taken, 0x300.
- Same-cycle collision: f_pc = e_pc = 0x40 with a taken-branch update, entry previously empty.
  - That cycle -> 0x44.
  - Next cycle -> target.
- Reset mid-run plus saturation:
  - With CNT_W = 4, 20 mispredicting updates -> perf_mispredicts = 15.
  - Assert rst together with an update -> all lookups miss and counters read 0 after reset.
